// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4-to-1 mux: steps the select through channels 0..3, waits a settle
// time on each one, samples the mux output and offers the assembled word on valid/ready.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE  = 1,
   parameter int unsigned CONT_EN = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       cont,
   input  logic       mux_out,
   output logic       s1,
   output logic       s0,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);
   localparam logic       CONT_ON    = (CONT_EN != 0);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] ch_q, ch_d;
   logic [3:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       cont_eff;

   assign cont_eff = CONT_ON & cont;

   // The channel register doubles as the registered mux select.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETTLE;
               ch_d    = 2'd0;
               cnt_d   = SETTLE_CNT;
               data_d  = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            data_d[ch_q] = mux_out;
            if (ch_q != 2'd3) begin
               ch_d    = ch_q + 2'd1;
               cnt_d   = SETTLE_CNT;
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_DONE;
               valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (ready) begin
               valid_d = 1'b0;
               ch_d    = 2'd0;
               if (cont_eff) begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_CNT;
                  data_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign s1    = ch_q[1];
   assign s0    = ch_q[0];
   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: four instances (different SETTLE/CONT_EN) each scanning a real 4-to-1 mux;
// a timing-formula reference model predicts select, busy, valid and data every cycle.
module tb_mux_scan_ctrl;

   localparam int MASK = 16383;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       cont;
   logic       ready;
   logic [3:0] ins;
   logic [1:0] act;

   logic [3:0]       st_w, mo_w, s1_w, s0_w, valid_w, busy_w;
   logic [3:0][3:0]  data_w;
   logic             s1_a, s0_a, valid_a, busy_a;
   logic [3:0]       data_a;

   int         cyc;
   logic [3:0] samp [0:MASK];
   int         q[$];
   logic [3:0] last_word;
   logic       exp_valid_prev;
   logic       prev_valid_act;
   int         rises;
   int         n_chk;
   int         n_pass;

   mux_scan_ctrl #(.SETTLE(1), .CONT_EN(1)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(st_w[0]), .cont(cont), .mux_out(mo_w[0]),
      .s1(s1_w[0]), .s0(s0_w[0]), .data(data_w[0]), .valid(valid_w[0]), .ready(ready), .busy(busy_w[0]));
   mux_scan_ctrl #(.SETTLE(0), .CONT_EN(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .start(st_w[1]), .cont(cont), .mux_out(mo_w[1]),
      .s1(s1_w[1]), .s0(s0_w[1]), .data(data_w[1]), .valid(valid_w[1]), .ready(ready), .busy(busy_w[1]));
   mux_scan_ctrl #(.SETTLE(255), .CONT_EN(1)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(st_w[2]), .cont(cont), .mux_out(mo_w[2]),
      .s1(s1_w[2]), .s0(s0_w[2]), .data(data_w[2]), .valid(valid_w[2]), .ready(ready), .busy(busy_w[2]));
   mux_scan_ctrl #(.SETTLE(1), .CONT_EN(0)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .start(st_w[3]), .cont(cont), .mux_out(mo_w[3]),
      .s1(s1_w[3]), .s0(s0_w[3]), .data(data_w[3]), .valid(valid_w[3]), .ready(ready), .busy(busy_w[3]));

   for (genvar g = 0; g < 4; g++) begin : g_mux
      assign mo_w[g] = ins[{s1_w[g], s0_w[g]}];
      assign st_w[g] = start && (act == 2'(g));
   end

   assign s1_a    = s1_w[act];
   assign s0_a    = s0_w[act];
   assign valid_a = valid_w[act];
   assign busy_a  = busy_w[act];
   assign data_a  = data_w[act];

   function automatic int settle_of(input logic [1:0] a);
      case (a)
         2'd0:    return 1;
         2'd1:    return 0;
         2'd2:    return 255;
         default: return 1;
      endcase
   endfunction

   function automatic logic ce_of(input logic [1:0] a);
      return (a != 2'd3);
   endfunction

   // Word as it stands d edges after the scan began: channel c is captured at edge e0+(c+1)*sp.
   function automatic logic [3:0] model_word(input int e0, input int sp, input int d);
      logic [3:0] w;
      w = '0;
      for (int c = 0; c < 4; c++) begin
         if (d >= (c + 1) * sp) w[c] = samp[(e0 + (c + 1) * sp) & MASK][c];
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_chk++;
      if (got === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d)", name, got, exp_v, act, cyc);
   endtask

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // samp[n] is the mux input vector seen by edge n.
   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         samp[(cyc + 1) & MASK] = ins;
         cyc = cyc + 1;
      end
   end

   initial begin : monitor
      int t, d, sp;
      logic [3:0] ew;
      logic ev, eb;
      logic [1:0] ec;
      forever begin
         @(posedge clock);
         #1;
         if (!reset_n) begin
            q.delete();
            last_word      = '0;
            exp_valid_prev = 1'b0;
            prev_valid_act = 1'b0;
            continue;
         end
         t  = cyc;
         sp = settle_of(act) + 2;
         if (exp_valid_prev && ready) begin
            if (q.size() != 0) begin
               last_word = model_word(q[0], sp, 4 * sp);
               void'(q.pop_front());
            end
            if (cont && ce_of(act)) q.push_back(t);
         end
         if (q.size() != 0 && q[0] <= t) begin
            d  = t - q[0];
            eb = 1'b1;
            ec = (d / sp >= 3) ? 2'd3 : 2'(d / sp);
            ev = (d >= 4 * sp);
            ew = model_word(q[0], sp, d);
         end else begin
            eb = 1'b0;
            ec = 2'd0;
            ev = 1'b0;
            ew = last_word;
         end
         chk("busy", 32'(busy_a), 32'(eb));
         chk("select", 32'({s1_a, s0_a}), 32'(ec));
         chk("valid", 32'(valid_a), 32'(ev));
         chk("data", 32'(data_a), 32'(ew));
         if (valid_a && !prev_valid_act) rises++;
         prev_valid_act = valid_a;
         exp_valid_prev = ev;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      if (q.size() == 0) q.push_back(cyc + 1);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic phase(input logic [1:0] k);
      @(negedge clock);
      act = k;
      #2 reset_n = 1'b0;
      #1 chk("reset_zero", 32'({s1_a, s0_a, data_a, valid_a, busy_a}), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic drain();
      start = 1'b0;
      cont  = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 1300; i++) begin
         if (q.size() == 0) break;
         @(negedge clock);
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      tick(2);
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         ins   = 4'($urandom);
         ready = (($urandom % 4) != 0);
         cont  = (($urandom % 3) == 0);
         start = (($urandom % 6) == 0);
         if (start && q.size() == 0) q.push_back(cyc + 1);
      end
      drain();
   endtask

   initial begin : stimulus
      int r0;
      n_chk = 0; n_pass = 0; rises = 0;
      reset_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b1; ins = 4'b0101; act = 2'd0;
      last_word = '0; exp_valid_prev = 1'b0; prev_valid_act = 1'b0;
      tick(2);

      // basic scan, SETTLE=1
      phase(2'd0);
      ins = 4'b0101; ready = 1'b1; cont = 1'b0;
      pulse_start();
      tick(16);
      drain();

      // backpressure: hold 20 cycles past valid
      ready = 1'b0;
      pulse_start();
      tick(11 + 20);
      ready = 1'b1;
      tick(4);
      drain();

      // continuous mode, inputs changed during the second word
      ins = 4'b1011; cont = 1'b1; ready = 1'b1;
      pulse_start();
      tick(12 + 5);
      ins = 4'b1000;
      tick(30);
      drain();

      // start pulses during SETTLE and DONE are ignored
      r0 = rises;
      ins = 4'($urandom); ready = 1'b0;
      pulse_start();
      tick(2);
      pulse_start();
      tick(12);
      pulse_start();
      tick(3);
      ready = 1'b1;
      tick(6);
      chk("one_handshake", 32'(rises - r0), 32'd1);
      drain();

      // asynchronous reset during channel 2 settle, then a fresh scan
      ins = 4'b0110;
      pulse_start();
      tick(6);
      #2 reset_n = 1'b0;
      #1 chk("midscan_reset", 32'({s1_a, s0_a, data_a, valid_a, busy_a}), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      ins = 4'b1001;
      pulse_start();
      tick(14);
      drain();

      random_traffic(800);

      // SETTLE=0
      phase(2'd1);
      ins = 4'b1110;
      pulse_start();
      tick(10);
      drain();
      random_traffic(400);

      // SETTLE=255
      phase(2'd2);
      ins = 4'b0011;
      pulse_start();
      tick(400);
      ins = 4'b1101;
      tick(640);
      drain();

      // CONT_EN=0: cont must be ignored
      phase(2'd3);
      ins = 4'b1010; cont = 1'b1; ready = 1'b1;
      r0 = rises;
      pulse_start();
      tick(40);
      chk("cont_disabled_words", 32'(rises - r0), 32'd1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
